// File: rtl/dmem_arb_pkg.sv
// Shared state encoding and port indices for the LEGLite data-memory arbiter.
// Optional build macro used by this block: ARB_CPU_PRIORITY_EN (see dmem_arb_pick).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way chooser used both when leaving IDLE and when an owner releases the port.
// ARB_CPU_PRIORITY_EN: ties always go to the CPU and the CPU cannot be preempted.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic preempt0_en
);

    always_comb begin
        winner = P_CPU;
        if (req0 && req1) begin
`ifdef ARB_CPU_PRIORITY_EN
            winner = P_CPU;
`else
            // Alternate away from whichever port owned the bus most recently.
            winner = ~last;
`endif
        end else if (req1) begin
            winner = P_DMA;
        end
    end

`ifdef ARB_CPU_PRIORITY_EN
    assign preempt0_en = 1'b0;
`else
    assign preempt0_en = 1'b1;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the LEGLite CPU data port and the DMA/debug loader
// in front of DMemory_IO. Build macro: ARB_CPU_PRIORITY_EN (CPU-priority variant).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 4,
    parameter int HC_W     = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e      state_q, state_d;
    logic            last_q, last_d;
    logic [HC_W-1:0] hold_q, hold_d;

    logic owner, req_own, req_oth, hold_max, preempt_ok;
    logic winner, preempt0_en;
    logic acc0, acc1;

    dmem_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last        (last_q),
        .winner      (winner),
        .preempt0_en (preempt0_en)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_d     = hold_q;
        owner      = (state_q == OWN1);
        req_own    = owner ? req1 : req0;
        req_oth    = owner ? req0 : req1;
        hold_max   = (hold_q == HC_W'(MAX_HOLD - 1));
        preempt_ok = owner | preempt0_en;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = winner ? OWN1 : OWN0;
                    hold_d  = '0;
                end
            end
            OWN0, OWN1: begin
                if (!req_own) begin
                    // Owner's request is low here, so the chooser can only pick the other port.
                    last_d  = owner;
                    hold_d  = '0;
                    state_d = (req0 || req1) ? (winner ? OWN1 : OWN0) : IDLE;
                end else if (req_oth && hold_max && preempt_ok) begin
                    last_d  = owner;
                    hold_d  = '0;
                    state_d = owner ? OWN0 : OWN1;
                end else if (!hold_max) begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);
    assign acc0 = gnt0 & req0;
    assign acc1 = gnt1 & req1;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (acc0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_write = wr0;
            mem_read  = ~wr0;
        end else if (acc1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_write = wr1;
            mem_read  = ~wr1;
        end
    end

    assign rvalid0   = acc0 & ~wr0;
    assign rvalid1   = acc1 & ~wr1;
    assign cpu_stall = req0 & ~gnt0;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for contention and
// async reset, then randomized requesters checked against an ownership-level model.
module tb_dmem_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef ARB_CPU_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clock, reset;
    logic        req0, req1, wr0, wr1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, cpu_stall, mem_write, mem_read;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem [16];

    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(.AW(16), .DW(16), .MAX_HOLD(MAX_HOLD), .HC_W(3)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Small DMemory_IO stand-in: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 10) ? 16'd77 : 16'h1000 + 16'(i);
        end else if (mem_write) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    typedef struct {
        bit r0; bit w0; logic [15:0] a0; logic [15:0] d0;
        bit r1; bit w1; logic [15:0] a1; logic [15:0] d1;
        bit g0; bit g1; bit w; bit r; bit rv0; bit rv1; bit st;
        logic [15:0] ea; logic [15:0] ewd; logic [15:0] erd;
    } vec_t;

    vec_t tbl [10];

    task automatic drive(input bit r0, input bit w0, input logic [15:0] a0, input logic [15:0] d0,
                         input bit r1, input bit w1, input logic [15:0] a1, input logic [15:0] d1);
        req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic check(input string name, input bit eg0, input bit eg1, input bit ew, input bit er,
                         input bit erv0, input bit erv1, input bit est,
                         input logic [15:0] ea, input logic [15:0] ewd, input logic [15:0] erd);
        logic [54:0] act, exp;
        act = {gnt0, gnt1, mem_write, mem_read, rvalid0, rvalid1, cpu_stall, mem_addr, mem_wdata, rdata};
        exp = {eg0, eg1, ew, er, erv0, erv1, est, ea, ewd, erd};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got {gnt0,gnt1,wr,rd,rv0,rv1,stall,addr,wdata,rdata}=%h expected %h",
                     name, act, exp);
        end
    endtask

    // Reference model: who owns the port, who owned it last, and how many accesses
    // the current owner has made since it was granted.
    int m_own;
    bit m_last;
    int m_streak;

    task automatic model_step();
        bit r [2];
        int x, y;
        r[0] = req0;
        r[1] = req1;
        if (m_own < 0) begin
            if (r[0] && r[1]) m_own = (PRIO || m_last) ? 0 : 1;
            else if (r[0])    m_own = 0;
            else if (r[1])    m_own = 1;
            m_streak = 0;
        end else begin
            x = m_own;
            y = 1 - x;
            if (!r[x]) begin
                m_last   = (x == 1);
                m_own    = r[y] ? y : -1;
                m_streak = 0;
            end else begin
                m_streak++;
                if (r[y] && m_streak >= MAX_HOLD && !(PRIO && x == 0)) begin
                    m_last   = (x == 1);
                    m_own    = y;
                    m_streak = 0;
                end
            end
        end
    endtask

    bit          pr [2];
    bit          pw [2];
    logic [15:0] pa [2];
    logic [15:0] pd [2];
    bit          e0, e1, a0, a1, ew, er;
    logic [15:0] ea, ewd;
    int          pat [10];

    initial begin
        tbl[0] = '{1,1,16'h0002,16'h0003, 0,0,16'h0000,16'h0000, 0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h1000};
        tbl[1] = '{1,1,16'h0002,16'h0003, 0,0,16'h0000,16'h0000, 1,0,1,0,0,0,0, 16'h0002,16'h0003,16'h1002};
        tbl[2] = '{0,1,16'h0002,16'h0003, 0,0,16'h0000,16'h0000, 1,0,0,0,0,0,0, 16'h0000,16'h0000,16'h1000};
        tbl[3] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,0,0,0, 16'h0000,16'h0000,16'h1000};
        tbl[4] = '{0,0,16'h0000,16'h0000, 1,0,16'h000A,16'h0055, 0,0,0,0,0,0,0, 16'h0000,16'h0000,16'h1000};
        tbl[5] = '{0,0,16'h0000,16'h0000, 1,0,16'h000A,16'h0055, 0,1,0,1,0,1,0, 16'h000A,16'h0055,16'd77};
        tbl[6] = '{1,0,16'h0005,16'h0000, 1,0,16'h000A,16'h0055, 0,1,0,1,0,1,1, 16'h000A,16'h0055,16'd77};
        tbl[7] = '{1,0,16'h0005,16'h0000, 0,0,16'h000A,16'h0055, 0,1,0,0,0,0,1, 16'h0000,16'h0000,16'h1000};
        tbl[8] = '{1,0,16'h0005,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,1,1,0,0, 16'h0005,16'h0000,16'h1005};
        tbl[9] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,0,0,0,0, 16'h0000,16'h0000,16'h1000};

        reset = 1'b0;
        drive(0,0,16'h0,16'h0, 0,0,16'h0,16'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #1;
            check($sformatf("table[%0d]", i), tbl[i].g0, tbl[i].g1, tbl[i].w, tbl[i].r,
                  tbl[i].rv0, tbl[i].rv1, tbl[i].st, tbl[i].ea, tbl[i].ewd, tbl[i].erd);
            @(negedge clock);
        end

        // Continuous contention straight out of reset.
        for (int i = 0; i < 10; i++) pat[i] = PRIO ? 0 : ((i >= 4 && i < 8) ? 1 : 0);
        reset = 1'b0;
        @(negedge clock);
        drive(1,1,16'h0001,16'h0011, 1,1,16'h0003,16'h0022);
        reset = 1'b1;
        #1;
        check("contend_idle", 0,0,0,0,0,0,1, 16'h0,16'h0, mem[0]);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            if (pat[i] == 0)
                check($sformatf("contend[%0d]", i), 1,0,1,0,0,0,0, 16'h0001,16'h0011, mem[1]);
            else
                check($sformatf("contend[%0d]", i), 0,1,1,0,0,0,1, 16'h0003,16'h0022, mem[3]);
        end

        // Reset dropped while port 0 is mid-write: outputs must fall without a clock edge.
        reset = 1'b0;
        #1;
        check("rst_async", 0,0,0,0,0,0,1, 16'h0,16'h0, mem[0]);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_release_idle", 0,0,0,0,0,0,1, 16'h0,16'h0, mem[0]);
        @(negedge clock);
        #1;
        check("rst_tie_port0", 1,0,1,0,0,0,0, 16'h0001,16'h0011, mem[1]);

        // Randomized requesters against the model.
        @(negedge clock);
        drive(0,0,16'h0,16'h0, 0,0,16'h0,16'h0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_own = -1; m_last = 1'b1; m_streak = 0;
        for (int p = 0; p < 2; p++) begin
            pr[p] = 1'b1; pw[p] = 1'($urandom); pa[p] = 16'($urandom); pd[p] = 16'($urandom);
        end
        for (int c = 0; c < 3000; c++) begin
            drive(pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1]);
            #1;
            e0  = (m_own == 0);
            e1  = (m_own == 1);
            a0  = e0 && req0;
            a1  = e1 && req1;
            ea  = a0 ? addr0  : (a1 ? addr1  : 16'h0);
            ewd = a0 ? wdata0 : (a1 ? wdata1 : 16'h0);
            ew  = (a0 && wr0) || (a1 && wr1);
            er  = (a0 && !wr0) || (a1 && !wr1);
            check($sformatf("rand[%0d]", c), e0, e1, ew, er, a0 && !wr0, a1 && !wr1,
                  req0 && !e0, ea, ewd, mem[ea[3:0]]);
            model_step();
            for (int p = 0; p < 2; p++) begin
                if ((p == 0 ? a0 : a1) || !pr[p]) begin
                    pr[p] = ($urandom_range(0, 99) < (((p == 0) ? a0 : a1) ? 60 : 30));
                    pw[p] = 1'($urandom);
                    pa[p] = 16'($urandom);
                    pd[p] = 16'($urandom);
                end
            end
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
